// File: rtl/mod_demux_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_demux_buf_if
//  Description : Handshake bundle for the buffered 1:2 demultiplexer.
//                Carries the input stream (valid/ready/data/sel), the flush
//                strobe, and the two output channels A and B with their
//                occupancy counts.
//  Modports    : master - producer/consumer side (drives inputs, readies)
//                slave  - demux side (drives in_ready, channel outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mod_demux_buf_if #(
    parameter int P_WIDTH    = 64,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [P_WIDTH-1:0] in_data;
    logic               in_sel;

    logic               a_valid;
    logic               a_ready;
    logic [P_WIDTH-1:0] a_data;
    logic [c_CNT_W-1:0] a_count;

    logic               b_valid;
    logic               b_ready;
    logic [P_WIDTH-1:0] b_data;
    logic [c_CNT_W-1:0] b_count;

    modport master (
        output flush, in_valid, in_data, in_sel, a_ready, b_ready,
        input  in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
    );

    modport slave (
        input  flush, in_valid, in_data, in_sel, a_ready, b_ready,
        output in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
    );
endinterface
`default_nettype wire

// File: rtl/mod_demux_buf.sv
`default_nettype none
// ============================================================================
//  Module      : mod_demux_buf
//  Description : Buffered 1:2 demultiplexer. One valid/ready input stream is
//                steered by in_sel (1 -> channel A, 0 -> channel B) into one
//                of two independent FIFOs, so back-pressure on one
//                destination never stalls words bound for the other.
//  Ports       : clk      - clock, rising edge
//                rst_n    - asynchronous active-low reset
//                bus      - mod_demux_buf_if.slave (flush, input stream,
//                           channel A/B outputs and occupancy counts)
//                stall_cnt- saturating count of refused input cycles
//                           (only when DEMUX_STALL_CNT_EN is defined)
//  Options     : DEMUX_STALL_CNT_EN - adds the stall_cnt port and counter
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_demux_buf #(
    parameter int P_WIDTH    = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mod_demux_buf_if.slave bus
`ifdef DEMUX_STALL_CNT_EN
    ,
    output logic [15:0]    stall_cnt
`endif
);
    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    // Channel index 1 is A, 0 is B, so in_sel indexes the channel directly.
    logic [1:0]         w_full;
    logic [1:0]         w_vld;
    logic [1:0]         w_out_ready;
    logic [P_WIDTH-1:0] w_head  [2];
    logic [c_CNT_W-1:0] w_count [2];
    logic               w_in_ready;
    logic               w_accept;

    // No bypass: a full channel refuses even if it pops this same cycle.
    assign w_in_ready  = rst_n & ~bus.flush & ~w_full[bus.in_sel];
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_out_ready = {bus.a_ready, bus.b_ready};

    genvar g;
    for (g = 0; g < 2; g++) begin : g_chan
        logic [P_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0] r_wr_ptr;
        logic [c_PTR_W-1:0] r_rd_ptr;
        logic [c_CNT_W-1:0] r_count;
        logic               w_push;
        logic               w_pop;
        logic               w_valid;

        assign w_valid  = (r_count != '0);
        assign w_push   = w_accept & (bus.in_sel == 1'(g));
        assign w_pop    = w_valid & w_out_ready[g];
        assign w_full[g] = (r_count == c_DEPTH);

        // Pointers wrap naturally because FIFO_DEPTH is a power of two.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CNT_W'(1);
                end
            end
        end

        // Storage is deliberately not reset; the count alone defines validity.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.in_data;
            end
        end

        assign w_head[g]  = w_valid ? r_mem[r_rd_ptr] : '0;
        assign w_vld[g]   = w_valid;
        assign w_count[g] = r_count;
    end

    assign bus.in_ready = w_in_ready;
    assign bus.a_valid  = w_vld[1];
    assign bus.a_data   = w_head[1];
    assign bus.a_count  = w_count[1];
    assign bus.b_valid  = w_vld[0];
    assign bus.b_data   = w_head[0];
    assign bus.b_count  = w_count[0];

`ifdef DEMUX_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // w_in_ready already folds in ~flush and rst_n, so a refused cycle is
    // in_valid & ~w_in_ready outside of the flush/reset branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (bus.flush) begin
            r_stall_cnt <= '0;
        end else if (bus.in_valid && !w_in_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_demux_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_demux_buf
//  Description : Self-checking bench for mod_demux_buf. A queue-based model
//                of the two channels is compared against the DUT every
//                falling edge; directed sequences add literal expectations,
//                followed by randomized traffic with flushes and resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_demux_buf;
    localparam int W = 64;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mod_demux_buf_if #(.P_WIDTH(W), .FIFO_DEPTH(D)) bus ();

`ifdef DEMUX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    mod_demux_buf #(.P_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DEMUX_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           m_stall = 0;
    bit           m_acc;

    function automatic bit exp_in_ready();
        if (!rst_n || bus.flush) return 1'b0;
        if (bus.in_sel) return qa.size() < D;
        return qb.size() < D;
    endfunction

    always @(negedge rst_n) begin
        qa.delete();
        qb.delete();
        m_stall = 0;
    end

    always @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            qa.delete();
            qb.delete();
            m_stall = 0;
        end else begin
            m_acc = bus.in_valid && exp_in_ready();
            if (bus.in_valid && !m_acc && m_stall < 16'hFFFF) m_stall++;
            if (bus.a_ready && qa.size() != 0) void'(qa.pop_front());
            if (bus.b_ready && qb.size() != 0) void'(qb.pop_front());
            if (m_acc) begin
                if (bus.in_sel) qa.push_back(bus.in_data);
                else            qb.push_back(bus.in_data);
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_in_ready()});
        chk("a_valid",  {63'd0, bus.a_valid},  {63'd0, qa.size() != 0});
        chk("b_valid",  {63'd0, bus.b_valid},  {63'd0, qb.size() != 0});
        chk("a_data",   bus.a_data, (qa.size() != 0) ? qa[0] : 64'd0);
        chk("b_data",   bus.b_data, (qb.size() != 0) ? qb[0] : 64'd0);
        chk("a_count",  64'(bus.a_count), 64'(qa.size()));
        chk("b_count",  64'(bus.b_count), 64'(qb.size()));
`ifdef DEMUX_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit v, input bit s, input logic [63:0] d,
                          input bit ar, input bit br, input bit fl);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
        bus.a_ready  = ar;
        bus.b_ready  = br;
        bus.flush    = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int guard;
        bit ar;
        bit acc;

        set_in(1'b1, 1'b1, 64'h99, 1'b1, 1'b1, 1'b0);
        repeat (3) step();
        chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("reset_a_count",  64'(bus.a_count), 64'd0);
        chk("reset_a_data",   bus.a_data, 64'd0);
        set_in(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Alternate A/B/A with both consumers ready.
        set_in(1'b1, 1'b1, 64'h11, 1'b1, 1'b1, 1'b0); step();
        chk("t1_a_count", 64'(bus.a_count), 64'd1);
        chk("t1_a_data",  bus.a_data, 64'h11);
        set_in(1'b1, 1'b0, 64'h22, 1'b1, 1'b1, 1'b0); step();
        chk("t1_a_count2", 64'(bus.a_count), 64'd0);
        chk("t1_b_data",   bus.b_data, 64'h22);
        set_in(1'b1, 1'b1, 64'h33, 1'b1, 1'b1, 1'b0); step();
        chk("t1_a_data3",  bus.a_data, 64'h33);
        chk("t1_b_count",  64'(bus.b_count), 64'd0);
        set_in(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0); step();
        chk("t1_a_empty_data", bus.a_data, 64'd0);

        // Fill A with its consumer stalled; B still accepts.
        for (int k = 1; k <= 4; k++) begin
            set_in(1'b1, 1'b1, 64'(k), 1'b0, 1'b1, 1'b0); step();
        end
        chk("t2_a_full_count", 64'(bus.a_count), 64'd4);
        set_in(1'b1, 1'b1, 64'd5, 1'b0, 1'b0, 1'b0); #1;
        chk("t2_a_full_ready", {63'd0, bus.in_ready}, 64'd0);
        set_in(1'b1, 1'b0, 64'h66, 1'b0, 1'b0, 1'b0); #1;
        chk("t2_b_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        chk("t2_b_count", 64'(bus.b_count), 64'd1);

        // Full A with a concurrent pop: push refused, then accepted.
        set_in(1'b1, 1'b1, 64'd5, 1'b1, 1'b0, 1'b0); #1;
        chk("t3_no_bypass", {63'd0, bus.in_ready}, 64'd0);
        step();
        chk("t3_count_3", 64'(bus.a_count), 64'd3);
        chk("t3_head_2",  bus.a_data, 64'd2);
        set_in(1'b1, 1'b1, 64'd5, 1'b0, 1'b0, 1'b0); step();
        chk("t3_count_4", 64'(bus.a_count), 64'd4);
        set_in(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        step(); chk("t3_head_3", bus.a_data, 64'd3);
        step(); chk("t3_head_4", bus.a_data, 64'd4);
        step(); chk("t3_head_5", bus.a_data, 64'd5);
        step(); chk("t3_drained", 64'(bus.a_count), 64'd0);

        // Wrap-around with a toggling consumer.
        sent = 0; guard = 0; ar = 1'b0;
        while (sent < 10 && guard < 100) begin
            set_in(1'b1, 1'b1, 64'(200 + sent), ar, 1'b1, 1'b0);
            #1 acc = bus.in_ready;
            step();
            if (acc) sent++;
            ar = ~ar;
            guard++;
        end
        chk("t4_sent_all", 64'(sent), 64'd10);
        set_in(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        repeat (D + 1) step();
        chk("t4_count_0", 64'(bus.a_count), 64'd0);
        chk("t4_data_0",  bus.a_data, 64'd0);

        // Flush with A=3, B=2 and a word offered in the flush cycle.
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 1'b1, 64'(8'h71 + k), 1'b0, 1'b0, 1'b0); step();
        end
        for (int k = 0; k < 2; k++) begin
            set_in(1'b1, 1'b0, 64'(8'h81 + k), 1'b0, 1'b0, 1'b0); step();
        end
        chk("t5_pre_a", 64'(bus.a_count), 64'd3);
        chk("t5_pre_b", 64'(bus.b_count), 64'd2);
        set_in(1'b1, 1'b1, 64'h77, 1'b0, 1'b0, 1'b1); step();
        chk("t5_a_count", 64'(bus.a_count), 64'd0);
        chk("t5_b_count", 64'(bus.b_count), 64'd0);
        chk("t5_a_valid", {63'd0, bus.a_valid}, 64'd0);
        set_in(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0); step();
        chk("t5_not_stored", 64'(bus.a_count), 64'd0);

`ifdef DEMUX_STALL_CNT_EN
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 1'b1, 64'(k), 1'b0, 1'b0, 1'b0); step();
        end
        chk("t6_stall_0", 64'(stall_cnt), 64'd0);
        set_in(1'b1, 1'b1, 64'hAA, 1'b0, 1'b0, 1'b0);
        repeat (5) step();
        chk("t6_stall_5", 64'(stall_cnt), 64'd5);
        set_in(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1); step();
        chk("t6_stall_flush", 64'(stall_cnt), 64'd0);
`endif

        // Randomized traffic: heavy back-pressure first, then light.
        for (int i = 0; i < 3000; i++) begin
            int rp;
            rp = (i < 1500) ? 3 : 1;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                set_in(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
                step();
                rst_n = 1'b1;
            end
            set_in($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   {$urandom, $urandom},
                   $urandom_range(0, rp) == 0, $urandom_range(0, rp) == 0,
                   $urandom_range(0, 63) == 0);
            step();
        end

        set_in(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mod_demux_buf.md
# mod_demux_buf

Buffered 1:2 demultiplexer for P_WIDTH-bit modular-arithmetic words: a single valid/ready input stream is steered by a per-word select bit into one of two independent FIFO-backed output channels. It is the steering counterpart of the 2:1 modular mux in the NTT/FFT datapath. Its job is to split butterfly results toward two destinations, A (e.g. upper bank) and B (lower bank), and to absorb short back-pressure on each destination separately.

## Interface
Parameters:
- P_WIDTH, 64, data word width
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, ≥ 2

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of both FIFOs
- in_valid  input  1  input word valid
- in_ready  output  1  input word accepted when in_valid & in_ready
- in_data  input  P_WIDTH  input word
- in_sel  input  1  1 → channel A, 0 → channel B (same polarity as the mux)
- a_valid  output  1  channel A head valid
- a_ready  input  1  channel A consumer ready
- a_data  output  P_WIDTH  channel A head word
- b_valid / b_ready / b_data  output / input / output  1 / 1 / P_WIDTH  channel B, same semantics as A
- a_count, b_count  output  $clog2(FIFO_DEPTH)+1  current occupancy of each FIFO
- stall_cnt  output  16  present only with DEMUX_STALL_CNT_EN

## Operation
- Each channel has its own FIFO: a memory, read/write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, and an occupancy counter.
- in_ready = rst_n & ~flush & ~full(selected channel). It is combinational in in_sel, so in_sel must be stable whenever in_valid is high.
- Push: when in_valid & in_ready, in_data is written at the selected channel's write pointer. The other channel is untouched.
- Pop: when x_valid & x_ready, the channel's read pointer advances.
- x_valid = (x_count != 0). x_data = mem[rd_ptr] when valid, otherwise 0.
- Push and pop on the same channel in the same cycle (not full, not empty): both pointers advance and the count is unchanged.
- Full channel: no bypass. in_ready stays low even if a pop occurs in the same cycle; the push is retried on the next cycle.
- Empty channel: no fall-through. A word pushed into an empty FIFO appears on the following cycle.
- Channels are independent. A stalled A never blocks words selected for B.
- flush = 1 for one cycle: both FIFOs go to pointers 0 and count 0. Any push or pop in that cycle is discarded. Data memory is not cleared.
- Ordering is preserved within each channel. There is no ordering relation between channels.

## Timing
- Reset (rst_n low, asynchronous): pointers 0, counts 0, a_valid = b_valid = 0, a_data = b_data = 0, in_ready = 0, stall_cnt = 0.
- First push is possible in the first clk edge after rst_n deasserts.
- Input-to-output latency: 1 cycle. A word accepted at edge N is visible on x_data/x_valid after edge N.
- Throughput: 1 word/cycle per input. Sustained full rate is possible on one channel with its consumer always ready.
- a_count/b_count update on the same edge as the push/pop.
- Reset asserted mid-transfer discards all buffered words immediately.

## Configuration
- DEMUX_STALL_CNT_EN defined:
  - stall_cnt port exists.
  - It increments on each cycle with in_valid & ~in_ready & rst_n & ~flush.
  - It saturates at 16'hFFFF.
  - It is cleared by reset and by flush.
- Undefined: the stall_cnt port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset then alternate pushes: push 0x11 (sel=1), 0x22 (sel=0), 0x33 (sel=1) with both consumers ready → A emits 0x11, 0x33; B emits 0x22; each word appears 1 cycle after acceptance; counts never exceed 1.
- Fill A (FIFO_DEPTH=4) with a_ready=0 using words 1..4 → a_count=4; a 5th word with sel=1 sees in_ready=0; a concurrent word with sel=0 is accepted into B.
- Channel A full, a_ready=1 and push sel=1 in the same cycle → push refused that cycle, accepted on the next; a_count goes 4→3→4; order 1,2,3,4,5 preserved.
- Wrap-around: 10 words through A with a_ready toggling every cycle → output order matches input; count returns to 0; a_data = 0 when empty.
- flush with A=3 entries and B=2 entries while in_valid=1 → next cycle both counts are 0, both valids are 0, and the flush-cycle input is not stored.
- With DEMUX_STALL_CNT_EN: hold A full and in_valid=1 with sel=1 for 5 cycles → stall_cnt=5; after a flush → 0.
